// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the mem_arbiter slice: default bus widths and FSM state encoding.
package mem_arbiter_pkg;

    localparam int unsigned MemAddrBus = 32;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned DefTimeout = 255;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        XFER_IF  = 2'd1,
        XFER_MEM = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and bus signal bundle for mem_arbiter; slave = arbiter view, master = environment view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MemAddrBus,
    parameter int unsigned DATA_W = RegBus
) ();

    logic                  if_re;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_flush;
    logic [DATA_W-1:0]     if_data;
    logic                  if_busy;
    logic                  if_done;

    logic                  mem_re;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_sel;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_busy;
    logic                  mem_done;

    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_sel;
    logic                  bus_ack;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    modport slave (
        input  if_re, if_addr, if_flush,
        output if_data, if_busy, if_done,
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
        output mem_rdata, mem_busy, mem_done,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        input  bus_ack, bus_rdata
    );

    modport master (
        output if_re, if_addr, if_flush,
        input  if_data, if_busy, if_done,
        output mem_re, mem_we, mem_addr, mem_wdata, mem_sel,
        input  mem_rdata, mem_busy, mem_done,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel, bus_err,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IF/MEM) single-bus arbiter, MEM has priority.
// Optional bus wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = MemAddrBus,
    parameter int unsigned DATA_W  = RegBus,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned SEL_W = DATA_W / 8;

    arb_state_t        state_q, state_d;
    logic              grant_mem_q, grant_mem_d;
    logic              flushed_q, flushed_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_busy_q, if_busy_d;
    logic              mem_busy_q, mem_busy_d;
    logic              timeout_hit;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_err_q;

    // Counter value N means N bus cycles already elapsed without ack.
    always_comb begin
        wait_cnt_d  = '0;
        timeout_hit = 1'b0;
        if (state_q == XFER_IF || state_q == XFER_MEM) begin
            wait_cnt_d  = wait_cnt_q + 1'b1;
            timeout_hit = !bus.bus_ack && (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        grant_mem_d = grant_mem_q;
        flushed_d   = flushed_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_busy_d   = if_busy_q;
        mem_busy_d  = mem_busy_q;

        case (state_q)
            IDLE: begin
                flushed_d  = 1'b0;
                if_busy_d  = bus.if_re && !bus.if_flush;
                mem_busy_d = 1'b0;
                if (bus.mem_re || bus.mem_we) begin
                    state_d     = XFER_MEM;
                    grant_mem_d = 1'b1;
                    mem_busy_d  = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = bus.mem_we;
                    bus_addr_d  = bus.mem_addr;
                    bus_wdata_d = bus.mem_wdata;
                    bus_sel_d   = bus.mem_sel;
                end else if (bus.if_re && !bus.if_flush) begin
                    state_d     = XFER_IF;
                    grant_mem_d = 1'b0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = bus.if_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = '1;
                end
            end
            XFER_IF: begin
                // A flushed fetch still runs to ack; only its result is discarded.
                if (bus.if_flush) begin
                    flushed_d = 1'b1;
                    if_busy_d = 1'b0;
                end
                if (bus.bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (!flushed_q && !bus.if_flush) begin
                        if_data_d = bus.bus_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                end
            end
            XFER_MEM: begin
                if_busy_d = if_busy_q && bus.if_re && !bus.if_flush;
                if (bus.bus_ack) begin
                    state_d     = DONE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    mem_rdata_d = bus.bus_rdata;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (grant_mem_q) begin
                    mem_busy_d = 1'b0;
                    if_busy_d  = if_busy_q && bus.if_re && !bus.if_flush;
                end else begin
                    if_busy_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_mem_q <= 1'b0;
            flushed_q   <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            if_busy_q   <= 1'b0;
            mem_busy_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_mem_q <= grant_mem_d;
            flushed_q   <= flushed_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_busy_q   <= if_busy_d;
            mem_busy_q  <= mem_busy_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            bus_err_q   <= timeout_hit;
`endif
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.if_busy   = if_busy_q;
    assign bus.mem_busy  = mem_busy_q;
    // A flush arriving in the DONE cycle itself still cancels the pulse.
    assign bus.if_done   = (state_q == DONE) && !grant_mem_q && !flushed_q && !bus.if_flush;
    assign bus.mem_done  = (state_q == DONE) && grant_mem_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.bus_err   = bus_err_q;
`else
    assign bus.bus_err   = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum bus wait cycles; used only under MEM_ARB_TIMEOUT_EN.
REQ-004 SHALL have clocking and reset ports as follows, decided: one clock; reset is asynchronous and active-high.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have the IF requester port as follows.
- if_re  in  1  instruction fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_flush  in  1  branch flush; discards the pending or in-flight fetch.
- if_data  out  DATA_W  fetched word.
- if_busy  out  1  fetch accepted or waiting, not yet done.
- if_done  out  1  one-cycle pulse; if_data valid.
REQ-006 SHALL have the MEM requester port as follows.
- mem_re  in  1  load request.
- mem_we  in  1  store request.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_sel  in  DATA_W/8  byte enables.
- mem_rdata  out  DATA_W  load data.
- mem_busy  out  1  access accepted or waiting.
- mem_done  out  1  one-cycle completion pulse.
REQ-007 SHALL have the bus port as follows.
- bus_req  out  1  transfer request.
- bus_we  out  1  write strobe.
- bus_addr  out  ADDR_W  address.
- bus_wdata  out  DATA_W  write data.
- bus_sel  out  DATA_W/8  byte enables.
- bus_ack  in  1  transfer complete; bus_rdata valid.
- bus_rdata  in  DATA_W  read data.
- bus_err  out  1  one-cycle timeout pulse.

Function
REQ-008 SHALL implement FSM states IDLE, XFER_IF, XFER_MEM, DONE.
REQ-009 In IDLE SHALL sample requests at the rising edge: (mem_re|mem_we) -> XFER_MEM, else if_re & !if_flush -> XFER_IF; MEM strictly wins ties.
REQ-010 On grant SHALL register address, wdata, sel and we (we=0 for IF) into bus outputs, holding them stable with bus_req=1 for every cycle in XFER_*.
REQ-011 mem_re & mem_we both high SHALL be treated as a store.
REQ-012 On bus_ack in XFER_* SHALL capture bus_rdata into the granted requester's data register, drop bus_req next cycle, and go to DONE.
REQ-013 In DONE SHALL pulse the granted requester's done for exactly one cycle, then return to IDLE; minimum latency request-edge to done = 2 cycles with ack on the first bus cycle.
REQ-014 if_data/mem_rdata SHALL hold their last value until the next completion of that requester.
REQ-015 xx_busy SHALL be high from the edge a request is sampled (granted or losing the tie) until the cycle after its done; a losing requester remains busy while its request stays asserted.
REQ-016 if_flush during XFER_IF SHALL let the bus transfer finish (no early bus_req drop) but suppress if_done and leave if_data unchanged; if_busy drops the cycle after flush.
REQ-017 if_flush coincident with IF DONE SHALL suppress that if_done pulse.
REQ-018 if_flush while IF waits behind MEM SHALL drop the pending fetch; a new if_re after flush is needed.
REQ-019 bus_ack outside XFER_* SHALL be ignored.

Reset
REQ-020 rst SHALL immediately force IDLE; bus_req, bus_we, bus_err, busy/done outputs = 0; bus_addr, bus_wdata, bus_sel, if_data, mem_rdata = 0; wait counter = 0.
REQ-021 Reset mid-transfer SHALL abandon it without any done pulse.

Configuration
REQ-022 With MEM_ARB_TIMEOUT_EN defined, a wait counter SHALL count XFER_* cycles; on reaching TIMEOUT without ack, drop bus_req, pulse bus_err and requester done (data unchanged), return to IDLE.
REQ-023 Without MEM_ARB_TIMEOUT_EN, the block SHALL wait indefinitely for bus_ack; bus_err SHALL be tied 0.

Structure
REQ-024 FSM state encoding and default widths SHALL live in the shared defines file alongside MemAddrBus/RegBus.
REQ-025 SHALL be a single module; no sub-modules.

Verification
REQ-026 Check single IF read: if_re, addr 0x100, ack after 3 cycles with data 0x00000013 -> if_done at cycle 5, if_data=0x00000013.
REQ-027 Check collision: if_re and mem_we (addr 0x2000, data 0xDEADBEEF, sel 0xF) in the same cycle -> store first; IF granted after mem_done; if_busy high throughout.
REQ-028 Check flush in flight: if_flush during XFER_IF, ack data 0x12345678 -> no if_done, if_data unchanged, bus_req dropped only after ack.
REQ-029 Check reset mid-transfer: rst during XFER_MEM -> all outputs 0 asynchronously; no mem_done afterwards.
REQ-030 Check timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=4), no ack -> bus_err and mem_done pulse after 4 bus cycles; state IDLE.
